hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage RV32I core: forwarding selects for E,
//  load-use stalls with configurable load latency, data-memory wait freeze, branch flush
//  arbitration, and saturating stall/flush performance counters. Sits beside the pipeline
//  registers; drives their stall/flush controls and the E-stage operand muxes.
// PARAMETERS
//  ADDRESS_WIDTH      5   register-index width
//  LOAD_STALL_CYCLES  1   cycles D is stalled on a load-use hazard (>=1; 1 = classic bubble)
//  COUNT_WIDTH        32  width of performance counters
// PORTS
//  clk         in   1     clock, all state on rising edge
//  rst         in   1     asynchronous, active-high reset
//  Rs1D, Rs2D  in   AW    source regs of instruction in D
//  Rs1E, Rs2E  in   AW    source regs of instruction in E
//  RdE, RdM, RdW in AW    destination regs in E/M/W
//  RegWriteM, RegWriteW in 1  write-enable of instruction in M/W
//  ResultSrcE  in   2     result select in E; 2'b01 = load
//  PCSrcE      in   1     taken branch/jump resolved in E
//  MemBusyM    in   1     data memory not ready for access in M
//  ForwardAE, ForwardBE out 2  E operand select: 0 regfile, 1 from W, 2 from M
//  StallF, StallD, StallE, StallM out 1  hold the corresponding pipeline register
//  FlushD, FlushE out 1   clear the D / E pipeline register to a bubble
//  StallCount  out  CW    saturating count of cycles with StallF=1
//  FlushCount  out  CW    saturating count of cycles with FlushD=1
// BEHAVIOUR
//  Forwarding (combinational): M has priority over W; never forward when source reg == 0.
//  Load-use: lu = (ResultSrcE==2'b01) & (RdE!=0) & ((Rs1D==RdE)|(Rs2D==RdE)).
//  FSM: RUN, LOAD_WAIT; 2-state, plus counter cnt of width clog2(LOAD_STALL_CYCLES+1).
//   RUN: lu & !PCSrcE & !MemBusyM -> StallF=StallD=FlushE=1 this cycle (combinational);
//        if LOAD_STALL_CYCLES>1 -> LOAD_WAIT, cnt<=LOAD_STALL_CYCLES-1.
//   LOAD_WAIT: StallF=StallD=FlushE=1; cnt decrements each non-busy cycle; cnt==1 -> RUN.
//   Total D stall per load-use = exactly LOAD_STALL_CYCLES non-busy cycles.
//  Branch: PCSrcE & !MemBusyM -> FlushD=FlushE=1; branch wins over lu (no stall, stays RUN).
//   PCSrcE in LOAD_WAIT is impossible (E holds a bubble) and is ignored.
//  MemBusyM=1: StallF=StallD=StallE=StallM=1, FlushD=FlushE=0, FSM and cnt frozen; a pending
//   PCSrcE or lu is held by the stalled registers and acted on when MemBusyM drops.
//  StallE/StallM asserted only by MemBusyM.
//  Counters: +1 per cycle on condition, saturate at all-ones, no wrap.
//  Reset (rst=1, any time incl. mid-stall): state RUN, cnt=0, counters=0; all Stall*/Flush*=0
//   while rst high; Forward* remain combinational. First post-reset cycle behaves as RUN.
// STRUCTURE
//  hazard_pkg: fwd_sel_t enum {FWD_RF=0, FWD_W=1, FWD_M=2}, RESULT_LOAD=2'b01,
//   hz_state_t enum {HZ_RUN, HZ_LOAD_WAIT}.
//  Sub-module fwd_sel (Rs, RdM, RdW, RegWriteM, RegWriteW -> fwd_sel_t), instantiated for A and B.
//  FSM/counters in this module; counters are one always_ff with saturation compare.
// TESTING
//  Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=2; Rs1E=0 same -> ForwardAE=0.
//  LOAD_STALL_CYCLES=3, load RdE=7, Rs2D=7 -> StallF/StallD/FlushE high 3 cycles, then RUN.
//  lu and PCSrcE same cycle -> FlushD=FlushE=1, StallD=0, StallCount unchanged, FlushCount +1.
//  MemBusyM high 4 cycles mid LOAD_WAIT (cnt=2) -> all stalls 1, flushes 0; stall resumes, ends on time.
//  rst pulse during LOAD_WAIT -> Stall*/Flush*=0 immediately, counters 0, next lu stalls normally.
//  COUNT_WIDTH=4, hold stall 20 cycles -> StallCount reaches 4'hF and stays.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: operand forward selects,
// the load result encoding and the load-use stall FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_t;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        HZ_RUN       = 1'b0,
        HZ_LOAD_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forward select for one E-stage source register.
// The younger result in M wins over W; x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [ADDRESS_WIDTH-1:0] Rs,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    output fwd_sel_t                 FwdSel
);

    always_comb begin
        FwdSel = FWD_RF;
        if (Rs != '0) begin
            if (RegWriteM && (RdM == Rs)) begin
                FwdSel = FWD_M;
            end else if (RegWriteW && (RdW == Rs)) begin
                FwdSel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage core: forwarding, load-use stalls of
// configurable length, memory-wait freeze, branch flush and perf counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int COUNT_WIDTH       = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcE,
    input  logic                     PCSrcE,
    input  logic                     MemBusyM,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic [COUNT_WIDTH-1:0]   StallCount,
    output logic [COUNT_WIDTH-1:0]   FlushCount
);

    localparam int              CNT_W    = $clog2(LOAD_STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    fwd_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_a (
        .Rs(Rs1E), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .FwdSel(fwd_a)
    );

    fwd_sel #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_fwd_b (
        .Rs(Rs2E), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .FwdSel(fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             stall_fd, stall_em, flush_d, flush_e;

    assign load_use = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_fd = 1'b0;
        stall_em = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        if (MemBusyM) begin
            // Whole pipe freezes; pending branch/load-use is replayed once memory is ready.
            stall_fd = 1'b1;
            stall_em = 1'b1;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (PCSrcE) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (load_use) begin
                        stall_fd = 1'b1;
                        flush_e  = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = HZ_LOAD_WAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                HZ_LOAD_WAIT: begin
                    stall_fd = 1'b1;
                    flush_e  = 1'b1;
                    cnt_d    = cnt_q - CNT_LAST;
                    if (cnt_q == CNT_LAST) begin
                        state_d = HZ_RUN;
                    end
                end
                default: state_d = HZ_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Controls are forced low for the whole reset pulse, not just from the next edge.
    assign StallF = stall_fd & ~rst;
    assign StallD = stall_fd & ~rst;
    assign StallE = stall_em & ~rst;
    assign StallM = stall_em & ~rst;
    assign FlushD = flush_d & ~rst;
    assign FlushE = flush_e & ~rst;

    logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushD && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule
